// File: rtl/result_uart_tx.sv
// Result byte buffer plus 8N1 serial transmitter: bytes arrive on a valid/ready
// handshake, queue in a small FIFO, and leave LSB-first on a single idle-high pin.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx, r_busy, r_ovf;

  logic w_full, w_empty, w_push, w_refuse, w_baud_tc, w_pop;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push    = in_valid && !w_full;
  assign w_refuse  = in_valid &&  w_full;
  assign w_baud_tc = (r_baud == BAUD_LAST);
  // Pop happens only on the edge that enters START, from IDLE or the end of STOP.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_tc));

  assign in_ready   = !w_full;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign ovf        = r_ovf;

  // Storage is not reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A refused push outranks a clear in the same cycle.
      if (w_refuse)     r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_tc) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_result_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       ovf;

  int ntests = 0;
  int nfail  = 0;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clr_ovf(clr_ovf), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle c of a frame (c=0 is the cycle right after tx falls).
  task automatic frame(input logic [7:0] b, input int first, input int last);
    logic e;
    int   idx;
    for (int c = first; c <= last; c++) begin
      idx = c / CPB;
      if (idx == 0)      e = 1'b0;
      else if (idx == 9) e = 1'b1;
      else               e = b[idx-1];
      chk($sformatf("frame_%02h_tx_c%0d", b, c), 32'(tx), 32'(e));
      chk("frame_busy", 32'(busy), 1);
      step();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"},    32'(tx), 1);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
    chk({tag, "_count"}, 32'(fifo_count), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
  endtask

  initial begin
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; clr_ovf = 1'b0;
    // 1: reset values and idle line
    step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_tx", 32'(tx), 1);
    end
    chk_reset_vals("idle");

    // 2: single byte
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_count_k", 32'(fifo_count), 1);
    chk("single_tx_k",    32'(tx), 1);
    step();
    chk("single_count_k1", 32'(fifo_count), 0);
    frame(8'hA5, 0, 39);
    chk("single_busy_end", 32'(busy), 0);
    chk("single_tx_end",   32'(tx), 1);

    // 3: burst of six into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      step();
      if (i == 1) chk("burst_count_e1", 32'(fifo_count), 1);
      if (i == 2) begin
        chk("burst_count_e2", 32'(fifo_count), 1);
        chk("burst_busy_e2",  32'(busy), 1);
        chk("burst_tx_e2",    32'(tx), 0);
      end
      if (i == 5) begin
        chk("burst_count_e5", 32'(fifo_count), 4);
        chk("burst_ready_e5", 32'(in_ready), 0);
        chk("burst_ovf_e5",   32'(ovf), 0);
      end
      if (i == 6) begin
        chk("burst_count_e6", 32'(fifo_count), 4);
        chk("burst_ovf_e6",   32'(ovf), 1);
      end
    end
    in_valid = 1'b0;
    frame(8'h01, 4, 39);
    frame(8'h02, 0, 39);
    frame(8'h03, 0, 39);
    frame(8'h04, 0, 39);
    frame(8'h05, 0, 39);
    chk("burst_busy_end",  32'(busy), 0);
    chk("burst_count_end", 32'(fifo_count), 0);
    chk("burst_ovf_end",   32'(ovf), 1);

    // 4: ovf clear, then set beats clear
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h11 + 8'(i); in_valid = 1'b1;
      step();
    end
    chk("ovf_fill_count", 32'(fifo_count), 4);
    in_data = 8'hEE; clr_ovf = 1'b1;
    step();
    in_valid = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins",     32'(ovf), 1);
    chk("ovf_no_overwrite", 32'(fifo_count), 4);

    // 5: asynchronous reset mid-frame
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst2");
    step();
    reset = 1'b0;
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_tx_start", 32'(tx), 0);
    for (int i = 0; i < 17; i++) step();
    chk("mid_busy_bit3", 32'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("post_rst_tx",   32'(tx), 1);
      chk("post_rst_busy", 32'(busy), 0);
    end
    in_data = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    frame(8'h81, 0, 39);
    chk("post81_busy", 32'(busy), 0);

    // 6: push on the STOP->START pop edge with two bytes queued
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC1 + 8'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("simul_count_pre", 32'(fifo_count), 2);
    frame(8'hC1, 1, 38);
    chk("simul_tx_last_stop", 32'(tx), 1);
    chk("simul_count_last",   32'(fifo_count), 2);
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("simul_count_post", 32'(fifo_count), 2);
    frame(8'hC2, 0, 39);
    frame(8'hC3, 0, 39);
    frame(8'h5A, 0, 39);
    chk("simul_busy_end",  32'(busy), 0);
    chk("simul_count_end", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Downstream output stage for the 8-bit logic unit: accepts each 8-bit result `Y` through a valid/ready handshake and buffers it in a small FIFO. It then transmits the result on a single pin as an 8N1 UART frame. This lets results leave the chip serially, so the remaining output pins are freed for status. The block sits between the `Y` bus of the logic unit and one dedicated output pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal values are 2 to 65535.
- `FIFO_DEPTH`, default 4: result buffer entries; must be a power of 2, minimum 2.

- `clk`  input  1: single clock; all state is updated on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `in_data`  input  8: result byte from the logic unit `Y` output.
- `in_valid`  input  1: `in_data` is valid this cycle.
- `in_ready`  output  1: FIFO can accept a byte; equals `!full`.
- `clr_ovf`  input  1: synchronous clear of `ovf`.
- `tx`  output  1: serial line; registered; idles high.
- `busy`  output  1: a frame is in progress (state is not IDLE).
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1: number of buffered bytes, 0 to FIFO_DEPTH.
- `ovf`  output  1: sticky flag; set on any cycle with `in_valid && !in_ready`.

## Operation
- **Push:** a byte is written when `in_valid && in_ready` at a rising edge.
  - `in_ready` depends only on full. When full, a push is refused even if a pop happens in the same cycle.
- **Pop:** the head byte is loaded into the shift register on the edge where the FSM leaves IDLE or STOP toward START.
- **Simultaneous push and pop** (not full): `fifo_count` is unchanged and both operations complete.
- **Pointers:** read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Full and empty are derived from `fifo_count`.
- **FSM states:**
  - IDLE: `tx` = 1. If `fifo_count` > 0, pop and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each lasting CLKS_PER_BIT cycles. The shift register shifts right after each bit. A 3-bit bit index counts 0 to 7; after bit 7, go to STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START directly with no idle gap; otherwise go to IDLE.
- **Baud counter:** counts 0 to CLKS_PER_BIT-1 and wraps. It is held at 0 in IDLE and advances the state/bit on its terminal count.
- **Overflow flag:**
  - `ovf` is set by a refused push and cleared by `clr_ovf`.
  - If both happen in the same cycle, set wins.
  - The refused byte is dropped; FIFO contents are never overwritten.
- **Reset while asserted:** forces the following, with remaining FIFO contents discarded:
  - `tx` = 1, `busy` = 0, `ovf` = 0, `fifo_count` = 0, `in_ready` = 1.
  - State = IDLE, pointers = 0, counters = 0.

## Timing
- **Reset values:** `tx` 1, `busy` 0, `in_ready` 1, `fifo_count` 0, `ovf` 0.
- **Reset is asynchronous.** Outputs take their reset values immediately on assertion, including mid-frame: `tx` returns high at once and the partial frame is abandoned. Deassertion is expected synchronous to `clk`.
- **Latency into an empty FIFO:** a push at edge k gives `fifo_count` = 1 after edge k. The pop happens at edge k+1, where `tx` falls and `busy` rises.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle after the last stop-bit cycle.
- **`fifo_count`:** updated on the same edge as the push or pop that changes it.
- **`in_ready`:** combinational from `fifo_count`, so it changes in the same cycle `fifo_count` changes.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. **Reset values:** after reset, check `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0, `ovf`=0. Hold for 20 idle cycles; `tx` must stay 1.
2. **Single byte:** push 0xA5 at edge k. At edge k+1, `tx` falls. `tx` then reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). `busy` drops after the stop bit and `fifo_count` returns to 0.
3. **Burst and overflow:** push 0x01 to 0x06 on consecutive edges 1 to 6.
   - 0x01 is popped at edge 2, and the FIFO is full after edge 5.
   - 0x06 is refused: `in_ready`=0 at edge 6 and `ovf`=1.
   - Serial output is 0x01 to 0x05 in order, in 5 back-to-back 40-cycle frames with no gaps.
4. **`ovf` priority:** with `ovf`=1, assert `clr_ovf` → `ovf`=0. Assert `clr_ovf` together with a refused push → `ovf` stays 1.
5. **Reset mid-frame:** push 0x3C, then assert reset during DATA bit 3.
   - `tx` goes to 1 immediately and `busy`=0, `fifo_count`=0.
   - After release, no frame is emitted for 100 cycles.
   - A new push of 0x81 transmits correctly.
6. **Simultaneous push and pop:** with `fifo_count`=2, push on the STOP→START pop edge → `fifo_count` stays 2 and byte order is preserved.
